// File: rtl/decode_sequencer.sv
// decode_sequencer
//   Top-level sequencer and SRAM arbiter for the image-decompression pipeline.
//   Detects a UART upload (start bit on UART_RX_I), ends it after
//   TIMEOUT_CYCLES cycles without a UART SRAM write, then runs the enabled
//   decode stages M1..M3 in ascending order using a level start / finish
//   handshake. The single SRAM controller port is granted to UART, the active
//   stage, or the VGA reader depending on state.
//
// Ports
//   CLOCK_50_I, Resetn          clock, synchronous active-low reset
//   UART_RX_I                   raw UART line (0 = start bit)
//   stage_enable[2:0]           stages to run, latched when the upload ends
//   UART_SRAM_*                 UART requester (address/data/we_n)
//   stage_SRAM_*[2:0]           per-stage requesters
//   VGA_SRAM_address            VGA reader (read only)
//   stage_finish[2:0]           stage done (level or pulse)
//   SRAM_*                      granted request to the SRAM controller
//   stage_start[2:0]            one-hot level start of the running stage
//   UART_rx_initialize/enable   UART receiver control
//   VGA_enable, busy            status
//   watchdog_error              sticky stage-timeout flag
//   run_cycles                  saturating cycle count of the last decode run
module decode_sequencer #(
    parameter int TIMEOUT_CYCLES  = 50000000,
    parameter int WATCHDOG_CYCLES = 67108863
) (
    input  logic             CLOCK_50_I,
    input  logic             Resetn,
    input  logic             UART_RX_I,
    input  logic [2:0]       stage_enable,
    input  logic [17:0]      UART_SRAM_address,
    input  logic [15:0]      UART_SRAM_write_data,
    input  logic             UART_SRAM_we_n,
    input  logic [2:0][17:0] stage_SRAM_address,
    input  logic [2:0][15:0] stage_SRAM_write_data,
    input  logic [2:0]       stage_SRAM_we_n,
    input  logic [17:0]      VGA_SRAM_address,
    input  logic [2:0]       stage_finish,
    output logic [17:0]      SRAM_address,
    output logic [15:0]      SRAM_write_data,
    output logic             SRAM_we_n,
    output logic [2:0]       stage_start,
    output logic             UART_rx_initialize,
    output logic             UART_rx_enable,
    output logic             VGA_enable,
    output logic             busy,
    output logic             watchdog_error,
    output logic [31:0]      run_cycles
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RX_INIT = 3'd1;
    localparam logic [2:0] S_RX      = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_ERROR   = 3'd5;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] WD_LAST = 32'(WATCHDOG_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [1:0]  cur_q, cur_d;
    logic [2:0]  en_q, en_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] wdog_q, wdog_d;
    logic [31:0] run_q, run_d;
    logic        wd_err_q, wd_err_d;

    // Requester and finish of the currently selected stage
    logic [17:0] cur_addr;
    logic [15:0] cur_data;
    logic        cur_we_n;
    logic        cur_fin;

    always_comb begin
        cur_addr = stage_SRAM_address[0];
        cur_data = stage_SRAM_write_data[0];
        cur_we_n = stage_SRAM_we_n[0];
        cur_fin  = stage_finish[0];
        case (cur_q)
            2'd1: begin
                cur_addr = stage_SRAM_address[1];
                cur_data = stage_SRAM_write_data[1];
                cur_we_n = stage_SRAM_we_n[1];
                cur_fin  = stage_finish[1];
            end
            2'd2: begin
                cur_addr = stage_SRAM_address[2];
                cur_data = stage_SRAM_write_data[2];
                cur_we_n = stage_SRAM_we_n[2];
                cur_fin  = stage_finish[2];
            end
            default: ;
        endcase
    end

    // First stage of a run: lowest set bit of stage_enable
    logic [1:0] first_idx;
    always_comb begin
        if (stage_enable[0])      first_idx = 2'd0;
        else if (stage_enable[1]) first_idx = 2'd1;
        else                      first_idx = 2'd2;
    end

    // Next enabled stage strictly above the current one
    logic       nxt_vld;
    logic [1:0] nxt_idx;
    always_comb begin
        nxt_vld = 1'b0;
        nxt_idx = 2'd0;
        case (cur_q)
            2'd0: begin
                if (en_q[1])      begin nxt_vld = 1'b1; nxt_idx = 2'd1; end
                else if (en_q[2]) begin nxt_vld = 1'b1; nxt_idx = 2'd2; end
            end
            2'd1: if (en_q[2]) begin nxt_vld = 1'b1; nxt_idx = 2'd2; end
            default: ;
        endcase
    end

    logic [31:0] run_inc;
    assign run_inc = (run_q == 32'hFFFF_FFFF) ? run_q : run_q + 32'd1;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        en_d     = en_q;
        timer_d  = timer_q;
        wdog_d   = wdog_q;
        run_d    = run_q;
        wd_err_d = wd_err_q;
        case (state_q)
            S_IDLE: begin
                if (!UART_RX_I) begin
                    state_d = S_RX_INIT;
                    timer_d = 32'd0;
                end
            end
            S_RX_INIT: state_d = S_RX;
            S_RX: begin
                // A write in the timeout cycle wins and restarts the quiet window
                if (!UART_SRAM_we_n) begin
                    timer_d = 32'd0;
                end else if (timer_q == TO_LAST) begin
                    timer_d = 32'd0;
                    en_d    = stage_enable;
                    run_d   = 32'd0;
                    wdog_d  = 32'd0;
                    cur_d   = first_idx;
                    state_d = (stage_enable == 3'b000) ? S_IDLE : S_RUN;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_RUN: begin
                run_d = run_inc;
                // Finish has priority over a watchdog expiry in the same cycle
                if (cur_fin) begin
                    state_d = S_GAP;
                end else if (wdog_q == WD_LAST) begin
                    wd_err_d = 1'b1;
                    state_d  = S_ERROR;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            S_GAP: begin
                run_d  = run_inc;
                wdog_d = 32'd0;
                if (nxt_vld) begin
                    cur_d   = nxt_idx;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            cur_q    <= 2'd0;
            en_q     <= 3'b000;
            timer_q  <= 32'd0;
            wdog_q   <= 32'd0;
            run_q    <= 32'd0;
            wd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            en_q     <= en_d;
            timer_q  <= timer_d;
            wdog_q   <= wdog_d;
            run_q    <= run_d;
            wd_err_q <= wd_err_d;
        end
    end

    // SRAM grant, decoded from the registered state
    logic [17:0] mux_addr;
    logic [15:0] mux_data;
    logic        mux_we_n;

    always_comb begin
        mux_addr = VGA_SRAM_address;
        mux_data = 16'd0;
        mux_we_n = 1'b1;
        case (state_q)
            S_RX_INIT, S_RX: begin
                mux_addr = UART_SRAM_address;
                mux_data = UART_SRAM_write_data;
                mux_we_n = UART_SRAM_we_n;
            end
            S_RUN: begin
                mux_addr = cur_addr;
                mux_data = cur_data;
                mux_we_n = cur_we_n;
            end
            S_GAP: mux_addr = 18'd0;
            default: ;
        endcase
    end

    assign SRAM_address    = mux_addr;
    assign SRAM_write_data = mux_data;
    // Block any write while reset is being applied, before the state clears
    assign SRAM_we_n       = Resetn ? mux_we_n : 1'b1;

    assign stage_start        = (state_q == S_RUN) ? (3'b001 << cur_q) : 3'b000;
    assign UART_rx_initialize = (state_q == S_RX_INIT);
    assign UART_rx_enable     = (state_q == S_RX);
    assign VGA_enable         = (state_q == S_IDLE) || (state_q == S_ERROR);
    assign busy               = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign watchdog_error     = wd_err_q;
    assign run_cycles         = run_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer with TIMEOUT_CYCLES=20, WATCHDOG_CYCLES=50.
// A stage responder raises stage_finish[i] on the FIN_LEN-th cycle that
// stage_start[i] is seen high, so each stage runs FIN_LEN cycles plus a
// 1-cycle gap. Inputs change and outputs are sampled at the falling edge.
module tb_decode_sequencer;

    localparam int FIN_LEN = 10;

    logic             clk;
    logic             Resetn;
    logic             UART_RX_I;
    logic [2:0]       stage_enable;
    logic [17:0]      UART_SRAM_address;
    logic [15:0]      UART_SRAM_write_data;
    logic             UART_SRAM_we_n;
    logic [2:0][17:0] stage_SRAM_address;
    logic [2:0][15:0] stage_SRAM_write_data;
    logic [2:0]       stage_SRAM_we_n;
    logic [17:0]      VGA_SRAM_address;
    logic [2:0]       stage_finish;
    logic [17:0]      SRAM_address;
    logic [15:0]      SRAM_write_data;
    logic             SRAM_we_n;
    logic [2:0]       stage_start;
    logic             UART_rx_initialize;
    logic             UART_rx_enable;
    logic             VGA_enable;
    logic             busy;
    logic             watchdog_error;
    logic [31:0]      run_cycles;

    decode_sequencer #(.TIMEOUT_CYCLES(20), .WATCHDOG_CYCLES(50)) dut (
        .CLOCK_50_I(clk), .Resetn(Resetn), .UART_RX_I(UART_RX_I),
        .stage_enable(stage_enable),
        .UART_SRAM_address(UART_SRAM_address),
        .UART_SRAM_write_data(UART_SRAM_write_data),
        .UART_SRAM_we_n(UART_SRAM_we_n),
        .stage_SRAM_address(stage_SRAM_address),
        .stage_SRAM_write_data(stage_SRAM_write_data),
        .stage_SRAM_we_n(stage_SRAM_we_n),
        .VGA_SRAM_address(VGA_SRAM_address),
        .stage_finish(stage_finish),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n), .stage_start(stage_start),
        .UART_rx_initialize(UART_rx_initialize),
        .UART_rx_enable(UART_rx_enable),
        .VGA_enable(VGA_enable), .busy(busy),
        .watchdog_error(watchdog_error), .run_cycles(run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Stage responder
    logic [2:0] auto_fin  = 3'b000;
    logic [2:0] force_fin = 3'b000;
    logic [2:0] resp_fin  = 3'b000;
    int         run_cnt [3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            run_cnt[i]  <= stage_start[i] ? run_cnt[i] + 1 : 0;
            resp_fin[i] <= auto_fin[i] && stage_start[i] && (run_cnt[i] + 1 == FIN_LEN);
        end
    end
    assign stage_finish = resp_fin | force_fin;

    // Upload bookkeeping
    logic [2:0] seq [$];
    logic [2:0] exp [$];
    int         rx_cycles;
    int         mux_bad;
    logic       timed_out;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add_stage(input int idx, input int len, input bit gap);
        for (int k = 0; k < len; k++) exp.push_back(3'b001 << idx);
        if (gap) exp.push_back(3'b000);
    endtask

    function automatic int first_diff();
        if (seq.size() != exp.size()) return -2;
        for (int k = 0; k < seq.size(); k++)
            if (seq[k] !== exp[k]) return k;
        return -1;
    endfunction

    // Start an upload from IDLE and follow it until the sequencer goes idle.
    // During RX the UART requester gets fresh values each cycle and the
    // granted port is compared against it; afterwards stage_start is logged.
    task automatic run_upload(input logic [2:0] en, input int we_period,
                              input int we_span, input int budget);
        int cyc;
        cyc = 0;
        seq.delete();
        rx_cycles    = 0;
        mux_bad      = 0;
        stage_enable = en;
        UART_RX_I    = 1'b0;
        tick();
        UART_RX_I = 1'b1;
        tick();
        while (busy && cyc < budget) begin
            if (UART_rx_enable) begin
                UART_SRAM_address    = 18'($urandom);
                UART_SRAM_write_data = 16'($urandom);
                UART_SRAM_we_n = (we_period > 0 && rx_cycles < we_span &&
                                  rx_cycles % we_period == 0) ? 1'b0 : 1'b1;
                #1;
                if (SRAM_address !== UART_SRAM_address ||
                    SRAM_write_data !== UART_SRAM_write_data ||
                    SRAM_we_n !== UART_SRAM_we_n) mux_bad++;
                rx_cycles++;
            end else begin
                UART_SRAM_we_n = 1'b1;
                seq.push_back(stage_start);
            end
            cyc++;
            tick();
        end
        UART_SRAM_we_n = 1'b1;
        timed_out = busy;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        VGA_SRAM_address = 18'h2A5A5;
        tick(); tick();
        #1;
        total++;
        if ({VGA_enable, busy, stage_start, UART_rx_initialize, UART_rx_enable,
             watchdog_error, SRAM_we_n} !== 9'b1_0_000_0_0_0_1)
            $display("FAIL reset_outputs: got %b want %b",
                     {VGA_enable, busy, stage_start, UART_rx_initialize,
                      UART_rx_enable, watchdog_error, SRAM_we_n}, 9'b1_0_000_0_0_0_1);
        else passed++;
        total++;
        if (run_cycles !== 32'd0) $display("FAIL reset_run_cycles: got %0d want 0", run_cycles);
        else passed++;
        Resetn = 1'b1;
        tick();
        VGA_SRAM_address = 18'h01234;
        #1;
        total++;
        if (SRAM_address !== 18'h01234 || SRAM_write_data !== 16'd0 || busy !== 1'b0)
            $display("FAIL idle_vga_grant: got addr %h data %h busy %b want addr 01234 data 0 busy 0",
                     SRAM_address, SRAM_write_data, busy);
        else passed++;
    endtask

    task automatic test_full_run();
        int d;
        auto_fin = 3'b111;
        run_upload(3'b111, 0, 0, 500);
        exp.delete();
        add_stage(0, FIN_LEN, 1); add_stage(1, FIN_LEN, 1); add_stage(2, FIN_LEN, 1);
        total++;
        if (timed_out) $display("FAIL full_run_done: sequencer still busy after budget");
        else passed++;
        total++;
        if (rx_cycles != 20) $display("FAIL full_rx_len: got %0d want 20", rx_cycles);
        else passed++;
        d = first_diff();
        total++;
        if (d != -1) $display("FAIL full_start_seq: diff at %0d (len %0d want %0d)", d, seq.size(), exp.size());
        else passed++;
        // 3 stages x (10 run cycles + 1 gap cycle)
        total++;
        if (run_cycles !== 32'd33) $display("FAIL full_run_cycles: got %0d want 33", run_cycles);
        else passed++;
        total++;
        if (VGA_enable !== 1'b1 || mux_bad != 0)
            $display("FAIL full_idle_after: VGA_enable %b mux_bad %0d want 1 and 0", VGA_enable, mux_bad);
        else passed++;
    endtask

    task automatic test_upload_writes();
        // Writes at RX cycles 0,15,...,90; then 20 quiet cycles 91..110
        run_upload(3'b000, 15, 100, 500);
        total++;
        if (rx_cycles != 111) $display("FAIL writes_rx_len: got %0d want 111", rx_cycles);
        else passed++;
        total++;
        if (mux_bad != 0) $display("FAIL writes_uart_grant: got %0d bad cycles want 0", mux_bad);
        else passed++;
        total++;
        if (seq.size() != 0 || run_cycles !== 32'd0 || timed_out)
            $display("FAIL zero_enable: got starts %0d run_cycles %0d want 0 and 0", seq.size(), run_cycles);
        else passed++;
    endtask

    task automatic test_skip();
        int d;
        run_upload(3'b101, 0, 0, 500);
        exp.delete();
        add_stage(0, FIN_LEN, 1); add_stage(2, FIN_LEN, 1);
        d = first_diff();
        total++;
        if (d != -1) $display("FAIL skip_start_seq: diff at %0d (len %0d want %0d)", d, seq.size(), exp.size());
        else passed++;
        total++;
        if (run_cycles !== 32'd22) $display("FAIL skip_run_cycles: got %0d want 22", run_cycles);
        else passed++;
    endtask

    task automatic test_min_stage();
        int d;
        auto_fin  = 3'b000;
        force_fin = 3'b001;
        run_upload(3'b001, 0, 0, 200);
        force_fin = 3'b000;
        exp.delete();
        add_stage(0, 1, 1);
        d = first_diff();
        total++;
        if (d != -1 || run_cycles !== 32'd2)
            $display("FAIL min_stage: diff %0d run_cycles %0d want -1 and 2", d, run_cycles);
        else passed++;
    endtask

    task automatic test_wrong_finish();
        int n;
        int bad;
        auto_fin     = 3'b000;
        force_fin    = 3'b110;
        stage_enable = 3'b001;
        UART_RX_I = 1'b0; tick(); UART_RX_I = 1'b1; tick();
        n = 0;
        while (stage_start == 3'b000 && n < 100) begin tick(); n++; end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (stage_start !== 3'b001 || SRAM_address !== stage_SRAM_address[0] ||
                SRAM_write_data !== stage_SRAM_write_data[0]) bad++;
            tick();
        end
        total++;
        if (bad != 0 || n >= 100) $display("FAIL wrong_finish_hold: got %0d bad cycles (wait %0d) want 0", bad, n);
        else passed++;
        force_fin = 3'b111;
        tick();
        #1;
        total++;
        if (stage_start !== 3'b000 || SRAM_address !== 18'd0 || SRAM_write_data !== 16'd0 || SRAM_we_n !== 1'b1)
            $display("FAIL gap_grant: got start %b addr %h data %h we_n %b want 000 0 0 1",
                     stage_start, SRAM_address, SRAM_write_data, SRAM_we_n);
        else passed++;
        force_fin = 3'b000;
        tick();
        total++;
        if (busy !== 1'b0) $display("FAIL gap_to_idle: got busy %b want 0", busy);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        int n;
        auto_fin        = 3'b111;
        stage_SRAM_we_n = 3'b000;
        stage_enable    = 3'b111;
        UART_RX_I = 1'b0; tick(); UART_RX_I = 1'b1; tick();
        n = 0;
        while (stage_start !== 3'b010 && n < 200) begin tick(); n++; end
        tick(); tick();
        #1;
        total++;
        if (SRAM_we_n !== 1'b0 || SRAM_address !== stage_SRAM_address[1] || n >= 200)
            $display("FAIL m2_grant: got we_n %b addr %h want 0 %h", SRAM_we_n, SRAM_address, stage_SRAM_address[1]);
        else passed++;
        Resetn = 1'b0;
        #1;
        total++;
        if (SRAM_we_n !== 1'b1) $display("FAIL reset_cycle_we_n: got %b want 1", SRAM_we_n);
        else passed++;
        tick();
        Resetn = 1'b1;
        #1;
        total++;
        if (stage_start !== 3'b000 || SRAM_we_n !== 1'b1 || SRAM_address !== VGA_SRAM_address || VGA_enable !== 1'b1)
            $display("FAIL reset_mid_run: got start %b we_n %b addr %h vga %b want 000 1 %h 1",
                     stage_start, SRAM_we_n, SRAM_address, VGA_enable, VGA_SRAM_address);
        else passed++;
        stage_SRAM_we_n = 3'b111;
        tick();
    endtask

    task automatic test_watchdog();
        int d;
        auto_fin = 3'b101;
        run_upload(3'b111, 0, 0, 500);
        exp.delete();
        add_stage(0, FIN_LEN, 1); add_stage(1, 50, 0);
        d = first_diff();
        total++;
        if (d != -1) $display("FAIL wd_start_seq: diff at %0d (len %0d want %0d)", d, seq.size(), exp.size());
        else passed++;
        total++;
        if (watchdog_error !== 1'b1 || busy !== 1'b0 || stage_start !== 3'b000 || VGA_enable !== 1'b1)
            $display("FAIL wd_error_state: got err %b busy %b start %b vga %b want 1 0 000 1",
                     watchdog_error, busy, stage_start, VGA_enable);
        else passed++;
        // M1 10 + gap 1 + M2 50
        total++;
        if (run_cycles !== 32'd61) $display("FAIL wd_run_cycles: got %0d want 61", run_cycles);
        else passed++;
        UART_RX_I = 1'b0; tick(); UART_RX_I = 1'b1; tick();
        total++;
        if (UART_rx_initialize !== 1'b0 || UART_rx_enable !== 1'b0 || busy !== 1'b0 || watchdog_error !== 1'b1)
            $display("FAIL error_ignores_rx: got init %b en %b busy %b err %b want 0 0 0 1",
                     UART_rx_initialize, UART_rx_enable, busy, watchdog_error);
        else passed++;
        Resetn = 1'b0; tick(); Resetn = 1'b1; tick();
        total++;
        if (watchdog_error !== 1'b0 || run_cycles !== 32'd0)
            $display("FAIL wd_cleared_by_reset: got err %b run %0d want 0 0", watchdog_error, run_cycles);
        else passed++;
    endtask

    initial begin
        Resetn                = 1'b0;
        UART_RX_I             = 1'b1;
        stage_enable          = 3'b000;
        UART_SRAM_address     = 18'd0;
        UART_SRAM_write_data  = 16'd0;
        UART_SRAM_we_n        = 1'b1;
        stage_SRAM_address    = {18'h30003, 18'h20002, 18'h10001};
        stage_SRAM_write_data = {16'hC3C3, 16'hB2B2, 16'hA1A1};
        stage_SRAM_we_n       = 3'b111;
        VGA_SRAM_address      = 18'd0;
        @(negedge clk);
        test_reset();
        test_full_run();
        test_upload_writes();
        test_skip();
        test_min_stage();
        test_wrong_finish();
        test_reset_mid_run();
        test_watchdog();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
